string_packer: RTL and testbench
================================

Name: string_packer

Overview:
- Transmit-side counterpart of string_comparator.
- Serializes a flagged string of up to 17 bytes onto a 32-bit word stream at a chosen byte offset, padding unused byte lanes with a fill byte.
- Generates word-aligned and shifted string traffic for the sniffer datapath, for example as comparator stimulus in loopback and self-test.
- Output stream uses a valid/ready handshake.

Parameters:
- MAXLEN, 17, maximum string length in bytes (flagged_string depth).
- WORD_BYTES, 4, bytes per output word (fixed; data_out is 32 bits).

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns to IDLE.
- start  input  1  begin a transfer; sampled only in IDLE.
- flagged_string  input  [0:16][7:0]  string bytes; index 0 is the first byte.
- strlen  input  5  string length in bytes, 0..31.
- offset  input  2  byte lane of the first string byte within the first word.
- fill_byte  input  8  value placed in non-string lanes.
- data_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  32  current word; lane 0 = [31:24], lane 3 = [7:0].
- data_valid  output  1  data_out holds a valid word.
- busy  output  1  high in SEND.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (n_rst low, async): data_out=0, data_valid=0, busy=0, done=0, state=IDLE, internal latches and counters=0.
- Reset mid-transfer aborts immediately; no done.
- States:
  - IDLE: default state.
  - SEND: words are being offered.
  - FIN: one cycle; done=1, data_valid=0.
  - FIN returns to IDLE.
- Start (IDLE, start=1 at edge N):
  - Latch flagged_string, strlen_eff=min(strlen,17), offset, fill_byte.
  - If strlen_eff=0: stay IDLE, no output, no done.
  - Otherwise: enter SEND. data_valid=1 and busy=1 from edge N, with word 0 on data_out. Latency is 1 cycle.
- Byte mapping:
  - Stream position p=offset+i for string byte i.
  - Byte goes to word p/4, lane p%4.
  - Lanes with no string byte carry fill_byte.
- Word count: nwords=ceil((offset+strlen_eff)/4), range 1..5. Maximum is 5 (offset 3, len 17 → 20 bytes).
- Handshake:
  - A word is transferred on an edge with data_valid & data_ready.
  - While data_ready=0, data_out and data_valid hold stable.
  - No bubbles: the next word appears the edge after acceptance.
- Last word accepted at edge M: edge M enters FIN (data_valid=0, busy=0, done=1). Edge M+1 returns to IDLE (done=0).
- A new start is accepted earliest in IDLE (edge M+1 sampling); start in SEND or FIN is ignored.
- Input changes after the start edge have no effect on the transfer in progress.
- clear=1 at any edge (priority over start and handshake):
  - Next state IDLE; data_out=0, data_valid=0, busy=0, done=0.
  - A word accepted on the same edge is discarded from the done accounting; no done.
- data_out=0 whenever data_valid=0.

Test Plan:
- "www.google.com", strlen=14, offset=0, fill 0x20, ready=1 → words "www.","goog","le.c","om  " on 4 consecutive cycles; done pulses on the following cycle; busy high exactly 4 cycles.
- Same string with offset=1 → " www",".goo","gle.","com ".
- Same string with offset=3 → "   w","ww.g","oogl","e.co","m   ".
- "abc", strlen=3, offset=3 → "   a","bc  ", 2 words.
- "www.linkedin.com/", strlen=17, offset=0 → "www.","link","edin",".com","/   ".
- strlen=20 behaves identically to strlen=17.
- Backpressure on the google case: ready=0 for 3 cycles while "goog" is presented → "goog" held stable with valid=1; stream resumes "le.c","om  "; done after the last acceptance.
- Abort and edge cases:
  - clear asserted while word 2 is presented → valid=0 and data_out=0 on the next cycle, no done, busy=0.
  - A subsequent start works normally.
  - strlen=0 with start → no valid, no done.
  - start pulsed in SEND → ignored.
  - n_rst low mid-transfer → all outputs 0 immediately.

Source files
------------

// File: rtl/string_packer.sv
// Serializes a latched string of up to MAXLEN bytes onto a 32-bit word stream
// at a byte offset, padding unused lanes with a fill byte (valid/ready out).
module string_packer #(
  parameter int MAXLEN     = 17,
  parameter int WORD_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic                      start,
  input  logic [0:MAXLEN-1][7:0]    flagged_string,
  input  logic [4:0]                strlen,
  input  logic [1:0]                offset,
  input  logic [7:0]                fill_byte,
  input  logic                      data_ready,
  output logic [8*WORD_BYTES-1:0]   data_out,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [0:MAXLEN-1][7:0]   str_q;
  logic [4:0]               len_q;
  logic [1:0]               off_q;
  logic [7:0]               fill_q;
  logic [2:0]               widx_q, widx_d;
  logic [2:0]               last_q;

  logic [4:0]               len_eff;
  logic [5:0]               span;
  logic [2:0]               last_idx;
  logic                     load;
  logic [8*WORD_BYTES-1:0]  word;

  assign len_eff  = (strlen > 5'(MAXLEN)) ? 5'(MAXLEN) : strlen;
  assign span     = {1'b0, len_eff} + {4'b0, offset};
  // Index of the final word; only used when len_eff is nonzero, so span >= 1.
  assign last_idx = 3'((span - 6'd1) >> 2);
  assign load     = (state_q == IDLE) && start && !clear;

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    if (clear) begin
      state_d = IDLE;
      widx_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (len_eff != 5'd0)) begin
            state_d = SEND;
            widx_d  = 3'd0;
          end
        end
        SEND: begin
          if (data_ready) begin
            if (widx_q == last_q) begin
              state_d = FIN;
              widx_d  = 3'd0;
            end else begin
              widx_d = widx_q + 3'd1;
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      widx_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      str_q  <= '0;
      len_q  <= 5'd0;
      off_q  <= 2'd0;
      fill_q <= 8'd0;
      last_q <= 3'd0;
    end else if (load) begin
      str_q  <= flagged_string;
      len_q  <= len_eff;
      off_q  <= offset;
      fill_q <= fill_byte;
      last_q <= last_idx;
    end
  end

  // Each lane maps back to string index (stream position - offset).
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [4:0] pos;
      logic [4:0] rel;
      logic [4:0] idx;
      logic       in_str;
      assign pos    = {widx_q, 2'b00} + 5'(gi);
      assign rel    = pos - {3'b000, off_q};
      assign in_str = (pos >= {3'b000, off_q}) && (rel < len_q);
      assign idx    = (rel < 5'(MAXLEN)) ? rel : 5'd0;
      assign word[8*(WORD_BYTES-1-gi) +: 8] = in_str ? str_q[idx] : fill_q;
    end
  endgenerate

  assign data_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign done       = (state_q == FIN);
  assign data_out   = data_valid ? word : '0;

endmodule

// File: tb/tb_string_packer.sv
// Scoreboard bench for string_packer: a byte-stream reference model queues the
// expected words; an independent monitor checks each accepted word and done.
module tb_string_packer;

  logic              clk;
  logic              n_rst;
  logic              clear;
  logic              start;
  logic [0:16][7:0]  flagged_string;
  logic [4:0]        strlen;
  logic [1:0]        offset;
  logic [7:0]        fill_byte;
  logic              data_ready;
  logic [31:0]       data_out;
  logic              data_valid;
  logic              busy;
  logic              done;

  typedef struct {
    logic [31:0] w;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  str_buf[17];
  bit          rdy_rand = 0;
  logic        rdy_val  = 1'b1;
  int          xfer_no  = 0;

  string_packer dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear          (clear),
    .start          (start),
    .flagged_string (flagged_string),
    .strlen         (strlen),
    .offset         (offset),
    .fill_byte      (fill_byte),
    .data_ready     (data_ready),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      data_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: lay the string out as a flat byte stream, then cut into words.
  task automatic model_push(input int len, input int off, input logic [7:0] fill);
    logic [7:0] stream[20];
    int eff, nw;
    exp_t e;
    eff = (len > 17) ? 17 : len;
    for (int k = 0; k < 20; k++) stream[k] = fill;
    for (int k = 0; k < eff; k++) stream[off + k] = str_buf[k];
    nw = (eff == 0) ? 0 : (off + eff + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      e.w    = {stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]};
      e.last = (w == nw - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic load_str(input string s);
    for (int k = 0; k < 17; k++)
      str_buf[k] = (k < s.len()) ? s[k] : 8'($urandom);
  endtask

  task automatic scramble_inputs();
    for (int k = 0; k < 17; k++) flagged_string[k] = 8'($urandom);
    strlen    = 5'($urandom);
    offset    = 2'($urandom);
    fill_byte = 8'($urandom);
  endtask

  task automatic start_xfer(input int len, input int off, input logic [7:0] fill);
    @(posedge clk);
    #1;
    for (int k = 0; k < 17; k++) flagged_string[k] = str_buf[k];
    strlen    = 5'(len);
    offset    = 2'(off);
    fill_byte = fill;
    start     = 1'b1;
    @(posedge clk);
    model_push(len, off, fill);
    xfer_no++;
    $display("xfer %0d: len=%0d off=%0d fill=%02h queued=%0d", xfer_no, len, off, fill, exp_q.size());
    #1;
    start = 1'b0;
    scramble_inputs();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout: %0d words still pending after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic        done_pend = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_word = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        done_pend = 1'b0;
        prev_hold = 1'b0;
      end else begin
        check("done", {31'b0, done}, {31'b0, done_pend});
        done_pend = 1'b0;
        check("valid", {31'b0, data_valid}, {31'b0, exp_q.size() > 0});
        check("busy", {31'b0, busy}, {31'b0, exp_q.size() > 0});
        if (!data_valid) check("idle_data_zero", data_out, 32'h0);
        if (prev_hold) check("hold_stable", data_out, prev_word);
        if (clear) begin
          exp_q.delete();
          prev_hold = 1'b0;
        end else begin
          if (data_valid && data_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("word", data_out, e.w);
            if (e.last) done_pend = 1'b1;
          end
          prev_hold = data_valid && !data_ready;
          prev_word = data_out;
        end
      end
    end
  end

  initial begin
    n_rst  = 1'b0;
    clear  = 1'b0;
    start  = 1'b0;
    scramble_inputs();
    #3;
    check("rst_data", data_out, 32'h0);
    check("rst_ctrl", {29'b0, data_valid, busy, done}, 32'h0);
    @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    rdy_rand = 0;
    rdy_val  = 1'b1;
    load_str("www.google.com");
    start_xfer(14, 0, 8'h20); drain();
    start_xfer(14, 1, 8'h20); drain();
    start_xfer(14, 3, 8'h20); drain();
    load_str("abc");
    start_xfer(3, 3, 8'h20); drain();
    load_str("www.linkedin.com/");
    start_xfer(17, 0, 8'h20); drain();
    start_xfer(20, 0, 8'h20); drain();
    start_xfer(31, 3, 8'h2e); drain();

    // Backpressure while "goog" is presented.
    load_str("www.google.com");
    start_xfer(14, 0, 8'h20);
    @(posedge clk);
    #1 rdy_val = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy_val = 1'b1;
    drain();

    // Clear while word 2 is presented.
    start_xfer(14, 0, 8'h20);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    drain();
    start_xfer(14, 2, 8'h5f); drain();

    // Zero length: nothing should come out.
    start_xfer(0, 1, 8'h20);
    drain();

    // Start pulsed during SEND is ignored.
    start_xfer(14, 0, 8'h20);
    #1 start = 1'b1;
    strlen = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Asynchronous reset mid-transfer.
    start_xfer(14, 1, 8'h20);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("arst_data", data_out, 32'h0);
    check("arst_ctrl", {29'b0, data_valid, busy, done}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #2 n_rst = 1'b1;
    drain();
    start_xfer(14, 0, 8'h20); drain();

    // Randomized traffic with random backpressure, aborts and stray starts.
    rdy_rand = 1;
    for (int t = 0; t < 40; t++) begin
      int len, off, act;
      for (int k = 0; k < 17; k++) str_buf[k] = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 17);
      off = $urandom_range(0, 3);
      start_xfer(len, off, 8'($urandom));
      act = $urandom_range(0, 3);
      if (act == 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        pulse_clear();
      end else if (act == 1 && exp_q.size() >= 2) begin
        #1 start = 1'b1;
        strlen = 5'd12;
        @(posedge clk);
        #1 start = 1'b0;
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
